wb_master_pipelined_burst: RTL
==============================

Name: wb_master_pipelined_burst

Overview:
Wishbone B4 pipelined bus master. It turns single-word or burst commands into pipelined classic cycles: one CYC per command, back-to-back STB, honouring STALL, and tracking outstanding ACKs. It is the initiator-side counterpart to our pipelined slaves and slave wrappers. DMA-style engines and test masters use it to drive the bus.

Parameters:
ADR_WIDTH, 16, word-address width of the bus; address increments by 1 per transfer.
DAT_WIDTH, 16, data width.
LEN_WIDTH, 8, width of cmd_len; transfers per command = cmd_len+1.
MAX_OUTSTANDING, 4, maximum transfers issued but not ACKed (>=1).

Ports:
clk  in  1  bus clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_we  in  1  1=write burst, 0=read burst
cmd_adr  in  ADR_WIDTH  start word address
cmd_len  in  LEN_WIDTH  transfer count minus one
wr_valid  in  1  write data available
wr_ready  out  1  write word consumed this cycle
wr_data  in  DAT_WIDTH  write data
rd_valid  out  1  read word valid (one cycle, no backpressure)
rd_data  out  DAT_WIDTH  read data
done  out  1  one-cycle pulse when the burst completes
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_we  out  1  write enable
wb_adr  out  ADR_WIDTH  address
wb_dat_o  out  DAT_WIDTH  write data to slave
wb_dat_i  in  DAT_WIDTH  read data from slave
wb_ack  in  1  slave acknowledge
wb_stall  in  1  slave stall

Behaviour:
- Reset (rst=0, async): state IDLE. wb_cyc, wb_stb, wb_we, done, rd_valid = 0. wb_adr, wb_dat_o = 0. All counters = 0. Effect is immediate, mid-burst included; no ACK is awaited.
- States: IDLE, BUSY.
  - IDLE -> BUSY on cmd_valid&cmd_ready. Latch we, adr, issue_cnt=cmd_len+1, ack_cnt=cmd_len+1. wb_cyc=1 from the next cycle.
  - BUSY -> IDLE on the edge where ack_cnt reaches 0. wb_cyc=0 and done=1 in the following cycle. done lasts one cycle. cmd_ready=1 in that same cycle.
- All wb_* outputs are registered. The strobe slot (wb_stb, wb_adr, wb_dat_o) is a one-entry holding register.
- accept = wb_stb & ~wb_stall. The slot may load when (~wb_stb | accept) & issue_cnt>0 & inflight_next < MAX_OUTSTANDING, and for writes also requires wr_valid.
  - On load: wb_stb<=1, wb_adr<=next address, wb_dat_o<=wr_data (writes). issue_cnt decrements.
  - wr_ready = load & we (combinational). It is never high for read commands or outside BUSY.
  - If the slot is accepted and cannot reload, wb_stb<=0.
- While stalled, wb_stb, wb_adr and wb_dat_o hold stable (B4 rule).
- inflight = transfers accepted but not ACKed, plus 1 if the slot is occupied. It never exceeds MAX_OUTSTANDING. An accept and an ACK in the same cycle net to zero.
- wb_ack decrements ack_cnt. On reads, rd_valid=wb_ack and rd_data=wb_dat_i in the same cycle (combinational pass-through).
- An ACK while ack_cnt==0 or outside BUSY is ignored.
- Address wraps modulo 2^ADR_WIDTH (0xFFFF+1 -> 0x0000).
- A write burst with wr_valid low inserts strobe bubbles. wb_cyc stays high.
- Latency, zero-wait slave that ACKs the cycle after accept, single read: cmd accepted cycle 0, stb cycle 1, ack/rd_valid cycle 2, done/cyc=0 cycle 3.
- cmd_len at maximum (255) gives 256 transfers with no counter overflow; counters are LEN_WIDTH+1 bits.

Test Plan:
- Single read, cmd_adr=0x0010, len=0, slave ACKs 1 cycle after accept with 0xBEEF -> wb_stb cycle 1 at adr 0x0010, rd_valid and 0xBEEF cycle 2, done and wb_cyc=0 cycle 3.
- Write burst len=3, adr=0x0100, wr_valid always 1, no stall -> 4 consecutive strobes at 0x0100..0x0103 with data in order. wr_ready high 4 cycles. done after the 4th ACK.
- Stall: read len=3 with wb_stall high for 3 cycles on the 2nd strobe -> wb_adr and wb_stb held for 3 cycles, 4 ACKs total, no duplicate or missed address.
- Outstanding limit: MAX_OUTSTANDING=4, read len=7, slave withholds ACKs -> exactly 4 accepts, then wb_stb=0. Each ACK allows one more strobe. Total 8 rd_valid.
- Wrap plus bubbles: write len=2 at 0xFFFF, wr_valid low every other cycle -> addresses 0xFFFF, 0x0000, 0x0001 with gaps in wb_stb and wb_cyc continuously high.
- Reset mid-burst: rst low while 2 transfers are outstanding -> wb_cyc and wb_stb drop immediately, no done. A new command after reset release works normally.

Source files
------------

// File: rtl/wb_master_pipelined_burst.sv
// Wishbone B4 pipelined bus master: turns single or burst commands into one CYC with
// back-to-back strobes, honouring STALL and capping the number of unacknowledged transfers.
module wb_master_pipelined_burst #(
  parameter int ADR_WIDTH       = 16,
  parameter int DAT_WIDTH       = 16,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [ADR_WIDTH-1:0] cmd_adr,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DAT_WIDTH-1:0] wr_data,
  output logic                 rd_valid,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 done,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [ADR_WIDTH-1:0] wb_adr,
  output logic [DAT_WIDTH-1:0] wb_dat_o,
  input  logic [DAT_WIDTH-1:0] wb_dat_i,
  input  logic                 wb_ack,
  input  logic                 wb_stall,
  output logic                 dbg_state
);

  localparam int CW = LEN_WIDTH + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 wb_cyc_q, wb_cyc_d;
  logic                 wb_stb_q, wb_stb_d;
  logic                 wb_we_q, wb_we_d;
  logic [ADR_WIDTH-1:0] wb_adr_q, wb_adr_d;
  logic [DAT_WIDTH-1:0] wb_dat_q, wb_dat_d;
  logic                 done_q, done_d;
  logic [ADR_WIDTH-1:0] adr_nxt_q, adr_nxt_d;
  logic [CW-1:0]        issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]        ack_cnt_q, ack_cnt_d;
  logic [OW-1:0]        outstanding_q, outstanding_d;

  logic          busy;
  logic          cmd_fire;
  logic          accept;
  logic          ack_eff;
  logic          out_dec;
  logic [OW-1:0] outstanding_nxt;
  logic          load;

  // Handshakes: cmd and wr words transfer on a cycle where valid & ready are both high;
  // ready never depends on a later cycle, and rd_valid is a one-cycle pulse with no backpressure.
  assign busy      = (state_q == BUSY);
  assign cmd_ready = (state_q == IDLE);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign accept    = wb_stb_q & ~wb_stall;
  assign ack_eff   = busy & wb_ack & (ack_cnt_q != '0);

  // outstanding_q counts accepted-but-unacked transfers; the occupied slot is added on top.
  assign out_dec         = ack_eff & ((outstanding_q != '0) | accept);
  assign outstanding_nxt = outstanding_q + OW'(accept) - OW'(out_dec);

  assign load = busy & (~wb_stb_q | accept) & (issue_cnt_q != '0) &
                (outstanding_nxt < MAX_OUT) & (~wb_we_q | wr_valid);

  assign wr_ready  = load & wb_we_q;
  assign rd_valid  = ack_eff & ~wb_we_q;
  assign rd_data   = wb_dat_i;
  assign done      = done_q;
  assign wb_cyc    = wb_cyc_q;
  assign wb_stb    = wb_stb_q;
  assign wb_we     = wb_we_q;
  assign wb_adr    = wb_adr_q;
  assign wb_dat_o  = wb_dat_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d       = state_q;
    wb_cyc_d      = wb_cyc_q;
    wb_stb_d      = wb_stb_q;
    wb_we_d       = wb_we_q;
    wb_adr_d      = wb_adr_q;
    wb_dat_d      = wb_dat_q;
    done_d        = 1'b0;
    adr_nxt_d     = adr_nxt_q;
    issue_cnt_d   = issue_cnt_q;
    ack_cnt_d     = ack_cnt_q;
    outstanding_d = outstanding_q;

    if (cmd_fire) begin
      state_d       = BUSY;
      wb_cyc_d      = 1'b1;
      wb_we_d       = cmd_we;
      ack_cnt_d     = {1'b0, cmd_len} + CW'(1);
      outstanding_d = '0;
      // Reads need no data, so the first strobe is loaded with the command itself;
      // writes wait for BUSY so wr_ready only ever fires inside the burst.
      if (!cmd_we) begin
        wb_stb_d    = 1'b1;
        wb_adr_d    = cmd_adr;
        adr_nxt_d   = cmd_adr + ADR_WIDTH'(1);
        issue_cnt_d = {1'b0, cmd_len};
      end else begin
        adr_nxt_d   = cmd_adr;
        issue_cnt_d = {1'b0, cmd_len} + CW'(1);
      end
    end else if (busy) begin
      outstanding_d = outstanding_nxt;
      if (ack_eff) begin
        ack_cnt_d = ack_cnt_q - CW'(1);
      end
      if (load) begin
        wb_stb_d    = 1'b1;
        wb_adr_d    = adr_nxt_q;
        adr_nxt_d   = adr_nxt_q + ADR_WIDTH'(1);
        issue_cnt_d = issue_cnt_q - CW'(1);
        if (wb_we_q) begin
          wb_dat_d = wr_data;
        end
      end else if (accept) begin
        wb_stb_d = 1'b0;
      end
      if (ack_eff && (ack_cnt_q == CW'(1))) begin
        state_d       = IDLE;
        wb_cyc_d      = 1'b0;
        wb_stb_d      = 1'b0;
        done_d        = 1'b1;
        outstanding_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wb_cyc_q      <= 1'b0;
      wb_stb_q      <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_adr_q      <= '0;
      wb_dat_q      <= '0;
      done_q        <= 1'b0;
      adr_nxt_q     <= '0;
      issue_cnt_q   <= '0;
      ack_cnt_q     <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      wb_cyc_q      <= wb_cyc_d;
      wb_stb_q      <= wb_stb_d;
      wb_we_q       <= wb_we_d;
      wb_adr_q      <= wb_adr_d;
      wb_dat_q      <= wb_dat_d;
      done_q        <= done_d;
      adr_nxt_q     <= adr_nxt_d;
      issue_cnt_q   <= issue_cnt_d;
      ack_cnt_q     <= ack_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  a_inflight_cap: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, outstanding_q} + (OW+1)'(wb_stb_q)) <= (OW+1)'(MAX_OUTSTANDING));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
    (wb_stb_q && wb_stall) |=> (wb_stb_q && $stable(wb_adr_q) && $stable(wb_dat_q)));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst)
    done_q |=> !done_q);

endmodule
